mul_issue_arbiter: RTL and testbench

// Shares the single pipelined integer multiplier between NUM_PORTS integer issue ports.

---
 rtl/mul_issue_arbiter.sv | 151 +++++++++++++++
 tb/tb_mul_issue_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_arbiter.sv
// Arbiter sharing one pipelined multiplier between several issue ports: buffers uops per port,
// discards mispredicted ones and issues the oldest surviving uop (by wrap-safe sqN) each cycle.
module mul_issue_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int BUF_DEPTH = 2,
    parameter int SQN_W     = 7,
    parameter int PAYLOAD_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           IN_branch_taken,
    input  logic [SQN_W-1:0]               IN_branch_sqN,
    input  logic [NUM_PORTS-1:0]           IN_uop_valid,
    input  logic [NUM_PORTS*SQN_W-1:0]     IN_uop_sqN,
    input  logic [NUM_PORTS*PAYLOAD_W-1:0] IN_uop_payload,
    output logic [NUM_PORTS-1:0]           OUT_busy,
    input  logic                           IN_mulBusy,
    output logic                           OUT_uop_valid,
    output logic [SQN_W-1:0]               OUT_uop_sqN,
    output logic [PAYLOAD_W-1:0]           OUT_uop_payload,
    output logic                           OUT_overflow
);

    localparam int NE    = NUM_PORTS * BUF_DEPTH;
    localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

    logic [NE-1:0]          vld_q, vld_d;
    logic [SQN_W-1:0]       sqn_q [NE];
    logic [SQN_W-1:0]       sqn_d [NE];
    logic [PAYLOAD_W-1:0]   pl_q  [NE];
    logic [PAYLOAD_W-1:0]   pl_d  [NE];
    logic [NUM_PORTS-1:0]   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic                   out_vld_q, out_vld_d;
    logic [SQN_W-1:0]       out_sqn_q, out_sqn_d;
    logic [PAYLOAD_W-1:0]   out_pl_q, out_pl_d;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   issue;
    logic [SQN_W-1:0]       in_sqn;
    logic                   placed;

    function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return $signed(diff) < 0;
    endfunction

    function automatic logic is_killed(input logic taken, input logic [SQN_W-1:0] bsqn,
                                       input logic [SQN_W-1:0] x);
        logic [SQN_W-1:0] diff;
        diff = x - bsqn;
        return taken && ($signed(diff) > 0);
    endfunction

    function automatic int port_count(input logic [NE-1:0] v, input int p);
        int n;
        n = 0;
        for (int k = 0; k < BUF_DEPTH; k++) begin
            if (v[p*BUF_DEPTH + k]) n++;
        end
        return n;
    endfunction

    // Oldest surviving entry; strict comparison keeps the lower port/entry on ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int e = 0; e < NE; e++) begin
            if (vld_q[e] && !is_killed(IN_branch_taken, IN_branch_sqN, sqn_q[e]) &&
                (!win_found || is_older(sqn_q[e], sqn_q[win_idx]))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(e);
            end
        end
        issue = win_found && !IN_mulBusy;
    end

    always_comb begin
        vld_d     = vld_q;
        sqn_d     = sqn_q;
        pl_d      = pl_q;
        ovf_d     = 1'b0;
        busy_d    = '0;
        in_sqn    = '0;
        placed    = 1'b0;
        out_vld_d = issue;
        out_sqn_d = out_sqn_q;
        out_pl_d  = out_pl_q;

        if (issue) begin
            out_sqn_d      = sqn_q[win_idx];
            out_pl_d       = pl_q[win_idx];
            vld_d[win_idx] = 1'b0;
        end

        for (int e = 0; e < NE; e++) begin
            if (vld_q[e] && is_killed(IN_branch_taken, IN_branch_sqN, sqn_q[e])) vld_d[e] = 1'b0;
        end

        // Fullness is judged on the stored count, but the slot freed by issue/flush may be reused.
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_sqn = IN_uop_sqN[p*SQN_W +: SQN_W];
            placed = 1'b0;
            if (IN_uop_valid[p] && !is_killed(IN_branch_taken, IN_branch_sqN, in_sqn)) begin
                if (port_count(vld_q, p) == BUF_DEPTH) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int k = 0; k < BUF_DEPTH; k++) begin
                        if (!placed && !vld_d[p*BUF_DEPTH + k]) begin
                            vld_d[p*BUF_DEPTH + k] = 1'b1;
                            sqn_d[p*BUF_DEPTH + k] = in_sqn;
                            pl_d[p*BUF_DEPTH + k]  = IN_uop_payload[p*PAYLOAD_W +: PAYLOAD_W];
                            placed                 = 1'b1;
                        end
                    end
                end
            end
            busy_d[p] = port_count(vld_d, p) >= BUF_DEPTH - 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            busy_q    <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        sqn_q     <= sqn_d;
        pl_q      <= pl_d;
        out_sqn_q <= out_sqn_d;
        out_pl_q  <= out_pl_d;
    end

    assign OUT_busy        = busy_q;
    assign OUT_overflow    = ovf_q;
    assign OUT_uop_valid   = out_vld_q;
    assign OUT_uop_sqN     = out_sqn_q;
    assign OUT_uop_payload = out_pl_q;

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Bench for mul_issue_arbiter: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a queue-based model of the buffers.
module tb_mul_issue_arbiter;

    localparam int NP  = 2;
    localparam int BD  = 2;
    localparam int SW  = 7;
    localparam int PW  = 16;

    typedef struct packed {
        logic [SW-1:0] sqn;
        logic [PW-1:0] pl;
    } ent_t;

    logic              clk;
    logic              rst;
    logic              br_taken;
    logic [SW-1:0]     br_sqn;
    logic [NP-1:0]     uop_valid;
    logic [NP*SW-1:0]  uop_sqn;
    logic [NP*PW-1:0]  uop_pl;
    logic [NP-1:0]     busy;
    logic              mul_busy;
    logic              out_valid;
    logic [SW-1:0]     out_sqn;
    logic [PW-1:0]     out_pl;
    logic              overflow;

    mul_issue_arbiter #(.NUM_PORTS(NP), .BUF_DEPTH(BD), .SQN_W(SW), .PAYLOAD_W(PW)) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_branch_taken (br_taken),
        .IN_branch_sqN   (br_sqn),
        .IN_uop_valid    (uop_valid),
        .IN_uop_sqN      (uop_sqn),
        .IN_uop_payload  (uop_pl),
        .OUT_busy        (busy),
        .IN_mulBusy      (mul_busy),
        .OUT_uop_valid   (out_valid),
        .OUT_uop_sqN     (out_sqn),
        .OUT_uop_payload (out_pl),
        .OUT_overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t          mq [NP][$];
    logic          exp_valid;
    logic [SW-1:0] exp_sqn;
    logic [PW-1:0] exp_pl;
    logic [NP-1:0] exp_busy;
    logic          exp_ovf;
    int            n_checks;
    int            n_fails;

    function automatic logic m_older(input logic [SW-1:0] a, input logic [SW-1:0] b);
        int d;
        d = (int'(a) - int'(b)) & 127;
        return d >= 64;
    endfunction

    function automatic logic m_killed(input logic [SW-1:0] x);
        int d;
        d = (int'(x) - int'(br_sqn)) & 127;
        return br_taken && d != 0 && d < 64;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        ent_t best;
        int   bp, bj;
        logic found;
        int   cnt_before [NP];
        ent_t keep [$];
        ent_t x;
        if (rst) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            exp_valid = 1'b0;
            exp_busy  = '0;
            exp_ovf   = 1'b0;
            return;
        end
        found = 1'b0;
        bp = 0; bj = 0; best = '0;
        for (int p = 0; p < NP; p++) begin
            cnt_before[p] = mq[p].size();
            for (int j = 0; j < mq[p].size(); j++) begin
                x = mq[p][j];
                if (!m_killed(x.sqn) && (!found || m_older(x.sqn, best.sqn))) begin
                    found = 1'b1; best = x; bp = p; bj = j;
                end
            end
        end
        exp_valid = found && !mul_busy;
        if (exp_valid) begin
            exp_sqn = best.sqn;
            exp_pl  = best.pl;
        end
        exp_ovf = 1'b0;
        for (int p = 0; p < NP; p++) begin
            keep.delete();
            for (int j = 0; j < mq[p].size(); j++) begin
                if (!(exp_valid && p == bp && j == bj) && !m_killed(mq[p][j].sqn)) keep.push_back(mq[p][j]);
            end
            mq[p] = keep;
            if (uop_valid[p] && !m_killed(uop_sqn[p*SW +: SW])) begin
                if (cnt_before[p] == BD) exp_ovf = 1'b1;
                else mq[p].push_back({uop_sqn[p*SW +: SW], uop_pl[p*PW +: PW]});
            end
            exp_busy[p] = mq[p].size() >= BD - 1;
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid && out_valid) begin
            check("model_sqn", 32'(out_sqn), 32'(exp_sqn));
            check("model_payload", 32'(out_pl), 32'(exp_pl));
        end
        check("model_busy", 32'(busy), 32'(exp_busy));
        check("model_overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic cyc(input logic v0, input logic [SW-1:0] s0, input logic v1, input logic [SW-1:0] s1,
                       input logic bt, input logic [SW-1:0] bs, input logic mb, input logic r);
        rst                 = r;
        uop_valid           = {v1, v0};
        uop_sqn             = {s1, s0};
        uop_pl              = {16'($urandom), 16'($urandom)};
        br_taken            = bt;
        br_sqn              = bs;
        mul_busy            = mb;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input logic mb);
        cyc(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, mb, 1'b0);
    endtask

    function automatic logic [SW-1:0] pick_sqn(input int p, input logic [SW-1:0] base);
        logic [SW-1:0] s;
        logic          dup;
        for (int tries = 0; tries < 64; tries++) begin
            s = base + SW'($urandom_range(0, 15));
            dup = 1'b0;
            for (int j = 0; j < mq[p].size(); j++) if (mq[p][j].sqn == s) dup = 1'b1;
            if (!dup) return s;
        end
        return base + 7'd40;
    endfunction

    initial begin
        logic [SW-1:0] base;
        logic [SW-1:0] s0, s1;
        n_checks = 0;
        n_fails  = 0;
        exp_valid = 1'b0; exp_sqn = '0; exp_pl = '0; exp_busy = '0; exp_ovf = 1'b0;

        cyc(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
        cyc(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_overflow", 32'(overflow), 32'd0);
        end

        // oldest across ports
        cyc(1'b1, 7'd5, 1'b1, 7'd3, 1'b0, 7'd0, 1'b0, 1'b0);
        check("pair_no_bypass", 32'(out_valid), 32'd0);
        idle(1'b0);
        check("pair_first_valid", 32'(out_valid), 32'd1);
        check("pair_first_sqn", 32'(out_sqn), 32'd3);
        idle(1'b0);
        check("pair_second_valid", 32'(out_valid), 32'd1);
        check("pair_second_sqn", 32'(out_sqn), 32'd5);
        idle(1'b0);
        check("pair_after_valid", 32'(out_valid), 32'd0);

        // wrapped sqN
        cyc(1'b1, 7'h7E, 1'b1, 7'h01, 1'b0, 7'd0, 1'b0, 1'b0);
        idle(1'b0);
        check("wrap_first_sqn", 32'(out_sqn), 32'h7E);
        idle(1'b0);
        check("wrap_second_sqn", 32'(out_sqn), 32'h01);
        idle(1'b0);

        // multiplier stall
        cyc(1'b1, 7'd20, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0);
        check("stall_busy0", 32'(busy), 32'b01);
        cyc(1'b1, 7'd21, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0);
        check("stall_busy1", 32'(busy), 32'b01);
        check("stall_no_issue1", 32'(out_valid), 32'd0);
        idle(1'b1);
        idle(1'b1);
        check("stall_no_issue3", 32'(out_valid), 32'd0);
        idle(1'b0);
        check("stall_out1_valid", 32'(out_valid), 32'd1);
        check("stall_out1_sqn", 32'(out_sqn), 32'd20);
        idle(1'b0);
        check("stall_out2_valid", 32'(out_valid), 32'd1);
        check("stall_out2_sqn", 32'(out_sqn), 32'd21);
        idle(1'b0);
        check("stall_done", 32'(out_valid), 32'd0);

        // mispredict flush on port1
        cyc(1'b0, 7'd0, 1'b1, 7'd10, 1'b0, 7'd0, 1'b1, 1'b0);
        cyc(1'b0, 7'd0, 1'b1, 7'd12, 1'b0, 7'd0, 1'b1, 1'b0);
        cyc(1'b0, 7'd0, 1'b1, 7'd11, 1'b1, 7'd10, 1'b0, 1'b0);
        check("flush_issue_sqn", 32'(out_sqn), 32'd10);
        check("flush_busy", 32'(busy), 32'd0);
        idle(1'b0);
        check("flush_nothing_left", 32'(out_valid), 32'd0);

        // overflow then reset mid-stall
        cyc(1'b1, 7'd30, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0);
        cyc(1'b1, 7'd31, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        cyc(1'b1, 7'd32, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        idle(1'b1);
        check("ovf_one_cycle", 32'(overflow), 32'd0);
        cyc(1'b1, 7'd34, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        idle(1'b0);
        check("rst_cleared", 32'(out_valid), 32'd0);

        // randomized traffic
        base = 7'd50;
        for (int i = 0; i < 3000; i++) begin
            s0 = pick_sqn(0, base);
            s1 = pick_sqn(1, base);
            cyc(($urandom_range(0, 99) < 50), s0, ($urandom_range(0, 99) < 50), s1,
                ($urandom_range(0, 99) < 8), base + SW'($urandom_range(0, 15)),
                ($urandom_range(0, 99) < 25), ($urandom_range(0, 999) < 5));
            base = base + 7'd1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
